// File: rtl/sine_rom_sequencer.sv
// sine_rom_sequencer
//   Phase-accumulator sequencer for a sine lookup ROM. The ROM has a
//   registered read port with a 1-cycle latency. A programmable tuning word
//   steps the phase, and the top bits of the phase form the ROM address.
//   Samples leave on a valid/ready stream with full backpressure. A run is
//   either continuous (num_samples == 0) or a fixed-length burst.
//
//   Optional build macro: QUARTER_WAVE_EN
//     When defined, the ROM holds only the first quarter wave. The address
//     is mirrored in odd quadrants, and the sample is negated in the second
//     half cycle. The sign bit is registered on issue, so it stays aligned
//     with the ROM read latency.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   start, stop      1-cycle control pulses (start in IDLE, stop in RUN)
//   tuning_word      phase increment, latched on an accepted start
//   num_samples      burst length, latched on start; 0 = continuous
//   rom_en/rom_addr  ROM read request (combinational)
//   rom_data         ROM registered read data
//   sample_*         output stream; a transfer is valid & ready
//   busy             high in RUN or DRAIN
//   done             1-cycle pulse on DRAIN -> IDLE
//   wrap             1-cycle pulse when an issue overflows the phase
module sine_rom_sequencer #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int PHASE_WIDTH = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [PHASE_WIDTH-1:0]    tuning_word,
    input  logic [COUNT_WIDTH-1:0]    num_samples,
    output logic                      rom_en,
    output logic [$clog2(DEPTH)-1:0]  rom_addr,
    input  logic [WIDTH-1:0]          rom_data,
    output logic [WIDTH-1:0]          sample_data,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      wrap
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = PHASE_WIDTH;
    localparam int CW = COUNT_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] phase, tw;
    logic [CW-1:0] count, len, count_nx;
    logic [PW:0]   phase_sum;
    logic          pend;
    logic          issue, xfer, accept;

    // The extra MSB of the sum is the carry-out, which drives wrap.
    assign phase_sum = {1'b0, phase} + {1'b0, tw};
    assign count_nx  = count + CW'(1);
    assign accept    = (state == IDLE) && start;
    assign xfer      = pend && sample_ready;

    // Issue only when the ROM register is free, or when it is emptied in
    // this same cycle. This keeps the ROM data stable during a stall.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                issue = !pend || sample_ready;
                // stop and the final issue in one cycle are a single exit;
                // the issue still happens.
                if (stop || ((len != '0) && issue && (count_nx == len)))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (!pend) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
            count <= '0;
            pend  <= 1'b0;
            tw    <= '0;
            len   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                tw    <= tuning_word;
                len   <= num_samples;
                phase <= '0;
                count <= '0;
            end
            if (issue) begin
                phase <= phase_sum[PW-1:0];
                count <= count_nx;
            end
            // Issue wins over transfer, so back-to-back keeps pend set.
            if (issue)     pend <= 1'b1;
            else if (xfer) pend <= 1'b0;
        end
    end

    assign rom_en       = issue;
    assign sample_valid = pend;
    assign busy         = (state != IDLE);
    assign wrap         = issue && phase_sum[PW];

`ifdef QUARTER_WAVE_EN
    logic [1:0]    quad;
    logic [AW-1:0] idx;
    logic          sign;

    assign quad = phase[PW-1:PW-2];
    assign idx  = phase[PW-3 -: AW];
    // Odd quadrants read the quarter table backwards.
    assign rom_addr = quad[0] ? (AW'(DEPTH - 1) - idx) : idx;

    // The sign follows the address through the one-cycle ROM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        sign <= 1'b0;
        else if (issue) sign <= quad[1];
    end

    assign sample_data = sign ? -rom_data : rom_data;
`else
    assign rom_addr    = phase[PW-1 -: AW];
    assign sample_data = rom_data;
`endif

endmodule

// File: tb/tb_sine_rom_sequencer.sv
module tb_sine_rom_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [15:0] tuning_word, num_samples;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] sample_data;
    logic        sample_valid, sample_ready;
    logic        busy, done, wrap;

    int tests = 0;
    int fails = 0;
    int n_xfer = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rom_mem [64];

    always #5 clk = ~clk;

    sine_rom_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .tuning_word(tuning_word), .num_samples(num_samples),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .done(done), .wrap(wrap)
    );

    // ROM model: registered read, 1-cycle latency, holds when not enabled
    initial rom_data = '0;
    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

    function automatic logic [31:0] rom_val(int a);
        return {16'hA5C3 ^ 16'(a), 16'(a * 37 + 11)};
    endfunction

    function automatic logic [5:0] exp_addr(logic [15:0] p);
        logic [5:0] idx;
`ifdef QUARTER_WAVE_EN
        idx = p[13:8];
        return p[14] ? (6'd63 - idx) : idx;
`else
        idx = p[15:10];
        return idx;
`endif
    endfunction

    function automatic logic [31:0] exp_data(logic [15:0] p);
        logic [31:0] v;
        v = rom_val(int'(exp_addr(p)));
`ifdef QUARTER_WAVE_EN
        if (p[15]) v = -v;
`endif
        return v;
    endfunction

    task automatic push_run(int tw, int n);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_data(16'((k * tw) & 16'hFFFF)));
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Leaves the bench at the first RUN cycle (posedge + 1). The tuning
    // word is scrambled after the start to show that it is not re-read.
    task automatic do_start(logic [15:0] tw, logic [15:0] len);
        tick();
        start = 1'b1; tuning_word = tw; num_samples = len;
        neg();
        chk("idle_busy", busy, 0);
        chk("idle_rom_en", rom_en, 0);
        tick();
        start = 1'b0; tuning_word = 16'h1234; num_samples = 16'd999;
    endtask

    task automatic wait_done(int bound, output int iss);
        bit found = 0;
        iss = 0;
        for (int i = 0; i < bound; i++) begin
            neg();
            if (rom_en) iss++;
            if (done) begin
                found = 1;
                chk("busy_at_done", busy, 1);
                tick();
                break;
            end
            tick();
        end
        chk("done_seen", found, 1);
        neg();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic chk_run_end(string nm, int n);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
        chk({nm, "_xfers"}, n_xfer, n);
    endtask

    // Scoreboard monitor: compares every transfer against the queue head
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && sample_valid && sample_ready) begin
            n_xfer++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL xfer_unexpected got=%0h exp=none", sample_data);
            end else begin
                e = exp_q.pop_front();
                if (sample_data !== e) begin
                    fails++;
                    $display("FAIL xfer_data got=%0h exp=%0h", sample_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int iss;
        logic [31:0] prev;
        bit prev_stall, found;
        for (int i = 0; i < 64; i++) rom_mem[i] = rom_val(i);
        rst = 1'b1; start = 0; stop = 0; tuning_word = 0; num_samples = 0; sample_ready = 0;
        neg(); neg();
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        tick(); rst = 1'b0;

        // 1: continuous run, address sweep, wrap, first-sample latency, stop
        push_run(16'h0400, 66); n_xfer = 0; sample_ready = 1;
        do_start(16'h0400, 0);
        for (int k = 0; k < 66; k++) begin
            stop = (k == 65);
            neg();
            chk("t1_rom_en", rom_en, 1);
            chk("t1_addr", rom_addr, exp_addr(16'((k * 16'h0400) & 16'hFFFF)));
            chk("t1_wrap", wrap, (k == 63));
            chk("t1_valid", sample_valid, (k != 0));
            tick();
        end
        stop = 0;
        wait_done(10, iss);
        chk("t1_drain_issues", iss, 0);
        chk_run_end("t1", 66);

        // 2: fixed burst of 5, then a burst of 3 with a zero tuning word
        push_run(16'h0400, 5); n_xfer = 0;
        do_start(16'h0400, 5);
        wait_done(20, iss);
        chk("t2_issues", iss, 5);
        chk_run_end("t2", 5);

        push_run(0, 3); n_xfer = 0;
        do_start(16'h0000, 3);
        wait_done(20, iss);
        chk("t2b_issues", iss, 3);
        chk_run_end("t2b", 3);

        // 3: backpressure during run cycles 3..6
        push_run(16'h0C00, 8); n_xfer = 0;
        do_start(16'h0C00, 8);
        found = 0; prev_stall = 0; prev = '0;
        for (int r = 1; r <= 40; r++) begin
            sample_ready = !(r >= 3 && r <= 6);
            neg();
            if (sample_valid && !sample_ready) begin
                chk("t3_stall_rom_en", rom_en, 0);
                if (prev_stall) chk("t3_stall_data", sample_data, prev);
            end
            prev_stall = sample_valid && !sample_ready;
            prev = sample_data;
            if (done) begin found = 1; tick(); break; end
            tick();
        end
        chk("t3_done_seen", found, 1);
        sample_ready = 1;
        chk_run_end("t3", 8);

        // 4: stop while a sample is pending and the output is stalled
        push_run(16'h0800, 3); n_xfer = 0; sample_ready = 1;
        do_start(16'h0800, 0);
        for (int r = 1; r <= 3; r++) begin neg(); tick(); end
        sample_ready = 0; stop = 1;
        neg();
        chk("t4_pend_at_stop", sample_valid, 1);
        tick(); stop = 0;
        for (int r = 0; r < 3; r++) begin
            neg();
            chk("t4_drain_busy", busy, 1);
            chk("t4_drain_rom_en", rom_en, 0);
            chk("t4_drain_done", done, 0);
            tick();
        end
        sample_ready = 1;
        wait_done(10, iss);
        chk("t4_drain_issues", iss, 0);
        chk_run_end("t4", 3);

        // 5: asynchronous reset mid-run, then a fresh run from phase 0
        push_run(16'h0400, 3); n_xfer = 0;
        do_start(16'h0400, 0);
        for (int r = 1; r <= 4; r++) begin neg(); tick(); end
        chk("t5_valid_before_rst", sample_valid, 1);
        rst = 1'b1; #1;
        chk("t5_rst_rom_en", rom_en, 0);
        chk("t5_rst_addr", rom_addr, 0);
        chk("t5_rst_valid", sample_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_wrap", wrap, 0);
        neg();
        tick(); rst = 1'b0;
        chk_run_end("t5", 3);
        push_run(16'h0400, 2); n_xfer = 0;
        do_start(16'h0400, 2);
        wait_done(20, iss);
        chk("t5b_issues", iss, 2);
        chk_run_end("t5b", 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
